// File: rtl/prbs_error_checker.sv
// Receive-side PRBS bit-error checker: self-synchronises a local LFSR to the
// incoming differential stream, then counts compared bits and bit errors.
module prbs_error_checker #(
    parameter int unsigned PRBS        = 7,
    parameter int unsigned LOCK_BITS   = 32,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned UNLOCK_ERRS = 8,
    parameter int unsigned CNT_W       = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_p,
    input  logic             in_n,
    output logic             locked,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] error_count,
    output logic             invalid_seen
);

    localparam int unsigned TAP     = (PRBS == 15) ? 14 : (PRBS == 31) ? 28 : 6;
    localparam int unsigned SEED_W  = $clog2(PRBS + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_BITS + 1);
    localparam int unsigned WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned WERR_W  = $clog2(UNLOCK_ERRS + 1);

    if (!(PRBS == 7 || PRBS == 15 || PRBS == 31)) begin : g_bad_prbs
        $error("prbs_error_checker: PRBS must be 7, 15 or 31");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEED    = 2'd1,
        S_ACQUIRE = 2'd2,
        S_CHECK   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PRBS-1:0]     lfsr_q, lfsr_d;
    logic [SEED_W-1:0]   seed_cnt_q, seed_cnt_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]   win_err_q, win_err_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                inv_q, inv_d;
    logic                locked_q, locked_d;

    logic            rx;
    logic            invalid;
    logic            pred;
    logic            err;
    logic            valid_match;
    logic            seed_done;
    logic            lock_done;
    logic            win_wrap;
    logic            unlock;
    logic [PRBS-1:0] lfsr_rx;

    // Sample decode and predictor shared by all states
    always_comb begin
        rx          = in_p;
        invalid     = (in_p == in_n);
        pred        = lfsr_q[PRBS-1] ^ lfsr_q[TAP-1];
        err         = invalid || (rx != pred);
        valid_match = !invalid && (rx == pred);
        lfsr_rx     = {lfsr_q[PRBS-2:0], rx};
        seed_done   = !invalid && (seed_cnt_q == SEED_W'(PRBS - 1));
        lock_done   = valid_match && (match_cnt_q == MATCH_W'(LOCK_BITS - 1));
        win_wrap    = (win_cnt_q == WIN_W'(WINDOW - 1));
        unlock      = err && (win_err_q == WERR_W'(UNLOCK_ERRS - 1));
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_SEED;
                S_SEED:    if (seed_done && (lfsr_rx != '0)) state_d = S_ACQUIRE;
                S_ACQUIRE: begin
                    if (!valid_match)   state_d = S_SEED;
                    else if (lock_done) state_d = S_CHECK;
                end
                S_CHECK:   if (unlock) state_d = S_SEED;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next-values
    always_comb begin
        lfsr_d      = lfsr_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        inv_d       = inv_q;

        if (enable) begin
            case (state_q)
                S_IDLE: seed_cnt_d = '0;
                S_SEED: begin
                    lfsr_d = lfsr_rx;
                    if (invalid || seed_done) begin
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    end
                end
                S_ACQUIRE: begin
                    if (valid_match) begin
                        lfsr_d      = lfsr_rx;
                        match_cnt_d = match_cnt_q + MATCH_W'(1);
                        if (lock_done) begin
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        seed_cnt_d = '0;
                    end
                end
                S_CHECK: begin
                    // Free-run on the prediction so a single flipped bit is a single error
                    lfsr_d = {lfsr_q[PRBS-2:0], pred};
                    if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
                    if (invalid) inv_d = 1'b1;
                    if (win_wrap) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        win_err_d = win_err_q + WERR_W'(err);
                    end
                    if (unlock) seed_cnt_d = '0;
                end
                default: ;
            endcase
        end

        if (clear) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
            inv_d     = 1'b0;
        end

        locked_d = (state_d == S_CHECK);
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q      <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            inv_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            inv_q       <= inv_d;
            locked_q    <= locked_d;
        end
    end

    assign locked       = locked_q;
    assign bit_count    = bit_cnt_q;
    assign error_count  = err_cnt_q;
    assign invalid_seen = inv_q;

endmodule

// File: tb/tb_prbs_error_checker.sv
// Directed bench for prbs_error_checker: PRBS7/PRBS15 lock timing, error
// counting, invalid samples, clear, unlock/relock, saturation and async reset.
module tb_prbs_error_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_p;
    logic       in_n;
    logic [2:0] en;

    logic        lk7,  iv7,  lk15, iv15, lks, ivs;
    logic [63:0] bc7,  ec7,  bc15, ec15;
    logic [7:0]  bcs,  ecs;

    logic [30:0] g;
    int          ord;
    int          n_vec = 0;
    int          n_err = 0;
    logic        ever;

    always #5 clk = ~clk;

    prbs_error_checker #(.PRBS(7)) u_p7 (
        .clock(clk), .reset_n(rst_n), .enable(en[0]), .clear(clear),
        .in_p(in_p), .in_n(in_n), .locked(lk7), .bit_count(bc7),
        .error_count(ec7), .invalid_seen(iv7)
    );

    prbs_error_checker #(.PRBS(15)) u_p15 (
        .clock(clk), .reset_n(rst_n), .enable(en[1]), .clear(clear),
        .in_p(in_p), .in_n(in_n), .locked(lk15), .bit_count(bc15),
        .error_count(ec15), .invalid_seen(iv15)
    );

    prbs_error_checker #(.PRBS(7), .CNT_W(8), .UNLOCK_ERRS(65)) u_sat (
        .clock(clk), .reset_n(rst_n), .enable(en[2]), .clear(clear),
        .in_p(in_p), .in_n(in_n), .locked(lks), .bit_count(bcs),
        .error_count(ecs), .invalid_seen(ivs)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n stream bits from the reference PRBS, optionally flipped or invalid
    task automatic send(input int n, input bit flip, input bit inval);
        int   tap;
        logic b;
        tap = (ord == 15) ? 14 : 6;
        for (int i = 0; i < n; i++) begin
            b    = g[ord-1] ^ g[tap-1];
            g    = {g[29:0], b};
            in_p = inval ? 1'b1 : (b ^ flip);
            in_n = inval ? 1'b1 : ~(b ^ flip);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 3'b000; clear = 1'b0;
        in_p = 1'b0; in_n = 1'b1; g = '1; ord = 7;
        tick(); tick();
        check("rst_locked", lk7, 0);
        check("rst_bits",   bc7, 0);
        check("rst_errs",   ec7, 0);
        check("rst_inv",    iv7, 0);
        rst_n = 1'b1;
        tick();

        // Constant-zero stream never locks
        en = 3'b001; ever = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (lk7) ever = 1'b1;
        end
        check("zero_nolock", ever, 0);
        check("zero_bits",   bc7,  0);
        check("zero_errs",   ec7,  0);
        en = 3'b000; tick();

        // PRBS7 lock at edge 39 after enable is first seen
        en = 3'b001;
        send(39, 0, 0);
        check("p7_prelock", lk7, 0);
        send(1, 0, 0);
        check("p7_lock", lk7, 1);
        send(1000, 0, 0);
        check("p7_bits1000", bc7, 1000);
        check("p7_errs0",    ec7, 0);

        // Invalid sample then clear
        send(1, 0, 1);
        check("inv_errs",   ec7, 1);
        check("inv_sticky", iv7, 1);
        check("inv_bits",   bc7, 1001);
        clear = 1'b1;
        send(1, 0, 0);
        clear = 1'b0;
        check("clr_bits",   bc7, 0);
        check("clr_errs",   ec7, 0);
        check("clr_inv",    iv7, 0);
        check("clr_locked", lk7, 1);
        send(10, 0, 0);
        check("post_clr_bits", bc7, 10);

        // Disable drops lock, counters hold; relock from IDLE
        en = 3'b000;
        send(1, 0, 0);
        check("dis_locked", lk7, 0);
        send(5, 0, 0);
        check("dis_hold", bc7, 10);
        en = 3'b001;
        send(39, 0, 0);
        check("relock_pre", lk7, 0);
        send(1, 0, 0);
        check("relock", lk7, 1);
        check("relock_bits", bc7, 10);

        // Eight flips within 16 bits force loss of lock on the 8th
        for (int k = 0; k < 8; k++) begin
            send(1, 0, 0);
            send(1, 1, 0);
            if (k == 6) begin
                check("burst7_locked", lk7, 1);
                check("burst7_errs",   ec7, 7);
            end
        end
        check("burst8_unlock", lk7, 0);
        check("burst8_errs",   ec7, 8);
        check("burst8_bits",   bc7, 26);
        send(38, 0, 0);
        check("burst_relock_pre", lk7, 0);
        send(1, 0, 0);
        check("burst_relock", lk7, 1);
        send(5, 0, 0);
        check("burst_cont_bits", bc7, 31);
        check("burst_cont_errs", ec7, 8);

        // PRBS15: single flipped bit is exactly one error
        en = 3'b000; tick();
        ord = 15; g = '1; en = 3'b010;
        send(47, 0, 0);
        check("p15_prelock", lk15, 0);
        send(1, 0, 0);
        check("p15_lock", lk15, 1);
        send(20, 0, 0);
        send(1, 1, 0);
        send(20, 0, 0);
        check("p15_errs",   ec15, 1);
        check("p15_locked", lk15, 1);
        check("p15_inv",    iv15, 0);
        check("p15_bits",   bc15, 41);

        // Saturation with 8-bit counters
        en = 3'b000; tick();
        ord = 7; g = '1; en = 3'b100;
        send(39, 0, 0);
        check("sat_prelock", lks, 0);
        send(1, 0, 0);
        check("sat_lock", lks, 1);
        send(300, 1, 0);
        check("sat_errs",   ecs, 255);
        check("sat_bits",   bcs, 255);
        check("sat_locked", lks, 1);

        // Asynchronous reset mid-CHECK, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_locked", lks, 0);
        check("arst_errs",   ecs, 0);
        check("arst_bits",   bcs, 0);
        check("arst_inv",    ivs, 0);
        check("arst_p15",    ec15, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
